// File: rtl/rref_pkg.sv
// rref_pkg: sizes, FSM states and matrix types
// shared by the fraction-free Gauss-Jordan reducer.
package rref_pkg;

  localparam int N = 5;
  localparam int W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SEARCH,
    S_SWAP,
    S_ELIM,
    S_DIV,
    S_NEXT,
    S_DONE
  } state_t;

  typedef logic signed [W-1:0] row_t [N];
  typedef row_t matrix_t [N];

  // sign-extend one element to product width
  function automatic logic signed [2*W-1:0] sx(
    input logic signed [W-1:0] v
  );
    return {{W{v[W-1]}}, v};
  endfunction

endpackage

// File: rtl/rref_2_seq_divider.sv
// seq_divider: signed 64/32 restoring divider.
// Two quotient bits per cycle, 32 iterations.
module seq_divider
  import rref_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  go,
  input  logic signed [2*W-1:0] num,
  input  logic signed [W-1:0]   den,
  output logic                  ready,
  output logic signed [W-1:0]   quo
);

  logic           busy;
  logic [4:0]     cnt;
  logic [2*W-1:0] sh;
  logic [W:0]     rem;
  logic [W:0]     dv;
  logic           neg;

  logic [2*W-1:0] num_mag;
  logic [W-1:0]   den_mag;
  logic [W:0]     t1, r1, t2, r2;
  logic           b1, b2;

  // operand magnitudes and one radix-4 restoring step
  always_comb begin
    num_mag = num[2*W-1] ? -num : num;
    den_mag = den[W-1] ? -den : den;
    t1 = (rem << 1) | {{W{1'b0}}, sh[2*W-1]};
    b1 = (t1 >= dv);
    r1 = b1 ? t1 - dv : t1;
    t2 = (r1 << 1) | {{W{1'b0}}, sh[2*W-2]};
    b2 = (t2 >= dv);
    r2 = b2 ? t2 - dv : t2;
  end

  // iteration state; quotient bits shift in as dividend bits leave
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
      sh   <= '0;
      rem  <= '0;
      dv   <= '0;
      neg  <= 1'b0;
    end else if (go && !busy) begin
      busy <= 1'b1;
      cnt  <= '0;
      sh   <= num_mag;
      rem  <= '0;
      dv   <= {1'b0, den_mag};
      neg  <= num[2*W-1] ^ den[W-1];
    end else if (busy) begin
      sh  <= {sh[2*W-3:0], b1, b2};
      rem <= r2;
      cnt <= cnt + 5'd1;
      if (cnt == 5'd31) busy <= 1'b0;
    end
  end

  assign ready = !busy;
  assign quo   = neg ? -sh[W-1:0] : sh[W-1:0];

endmodule

// File: rtl/rref_2.sv
// rref_2: sequential Bareiss Gauss-Jordan reducer
// for a 5x5 signed matrix, reporting every pivot.
module rref_2
  import rref_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic signed [W-1:0] a11, a12, a13, a14, a15,
  input  logic signed [W-1:0] a21, a22, a23, a24, a25,
  input  logic signed [W-1:0] a31, a32, a33, a34, a35,
  input  logic signed [W-1:0] a41, a42, a43, a44, a45,
  input  logic signed [W-1:0] a51, a52, a53, a54, a55,
  output logic signed [W-1:0] i11, i12, i13, i14, i15,
  output logic signed [W-1:0] i21, i22, i23, i24, i25,
  output logic signed [W-1:0] i31, i32, i33, i34, i35,
  output logic signed [W-1:0] i41, i42, i43, i44, i45,
  output logic signed [W-1:0] i51, i52, i53, i54, i55,
  output logic signed [W-1:0] pivot1, pivot2, pivot3,
  output logic signed [W-1:0] pivot4, pivot5,
  output logic                busy,
  output logic                done,
  output logic                singular
);

  localparam logic [2:0] LAST = 3'(N-1);

  state_t state, state_n;

  matrix_t a_in, m, res;
  row_t    piv, piv_q;

  logic [2:0] k, r, j, c, j_inc;

  logic signed [W-1:0]   pp, mjk, cand, colk, quo;
  logic signed [2*W-1:0] num;

  logic cand_nz, last_elem;
  logic div_go, div_ready;

  // gather the flat input ports into a matrix
  always_comb begin
    a_in[0] = '{a11, a12, a13, a14, a15};
    a_in[1] = '{a21, a22, a23, a24, a25};
    a_in[2] = '{a31, a32, a33, a34, a35};
    a_in[3] = '{a41, a42, a43, a44, a45};
    a_in[4] = '{a51, a52, a53, a54, a55};
  end

  // pivot candidate, shared multiplier pair, loop indices
  always_comb begin
    cand      = m[r][k];
    cand_nz   = (cand != '0);
    // column k of row j is overwritten at c == k, so later
    // columns take the value latched at c == 0
    colk      = (c == 3'd0) ? m[j][k] : mjk;
    num       = sx(m[k][k]) * sx(m[j][c])
              - sx(colk) * sx(m[k][c]);
    j_inc     = (j + 3'd1 == k) ? j + 3'd2 : j + 3'd1;
    last_elem = (c == LAST) && (j_inc > LAST);
    div_go    = (state == S_ELIM);
  end

  seq_divider u_div (
    .clk   (clk),
    .rst   (rst),
    .go    (div_go),
    .num   (num),
    .den   (pp),
    .ready (div_ready),
    .quo   (quo)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:   if (start) state_n = S_LOAD;
      S_LOAD:   state_n = S_SEARCH;
      S_SEARCH: begin
        if (cand_nz)
          state_n = (r == k) ? S_ELIM : S_SWAP;
        else if (r == LAST)
          state_n = S_DONE;
      end
      S_SWAP:   state_n = S_ELIM;
      S_ELIM:   state_n = S_DIV;
      S_DIV: begin
        if (div_ready)
          state_n = last_elem ? S_NEXT : S_ELIM;
      end
      S_NEXT:   state_n = (k == LAST) ? S_DONE : S_SEARCH;
      S_DONE:   state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  // working matrix, step indices and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int x = 0; x < N; x++) begin
        piv[x]   <= '0;
        piv_q[x] <= '0;
        for (int y = 0; y < N; y++) begin
          m[x][y]   <= '0;
          res[x][y] <= '0;
        end
      end
      k        <= '0;
      r        <= '0;
      j        <= '0;
      c        <= '0;
      pp       <= '0;
      mjk      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      singular <= 1'b0;
    end else begin
      done <= (state_n == S_DONE);
      busy <= (state_n != S_IDLE) && (state_n != S_DONE);
      unique case (state)
        S_IDLE: if (start) m <= a_in;
        S_LOAD: begin
          k  <= '0;
          r  <= '0;
          pp <= 32'sd1;
          for (int x = 0; x < N; x++) piv[x] <= '0;
        end
        S_SEARCH: begin
          if (cand_nz) begin
            piv[k] <= cand;
            j      <= (k == 3'd0) ? 3'd1 : 3'd0;
            c      <= '0;
          end else if (r != LAST) begin
            r <= r + 3'd1;
          end
        end
        S_SWAP: begin
          m[k] <= m[r];
          m[r] <= m[k];
        end
        S_ELIM: if (c == 3'd0) mjk <= m[j][k];
        S_DIV: begin
          if (div_ready) begin
            m[j][c] <= quo;
            if (c == LAST) begin
              c <= '0;
              if (!last_elem) j <= j_inc;
            end else begin
              c <= c + 3'd1;
            end
          end
        end
        S_NEXT: begin
          pp <= m[k][k];
          if (k != LAST) begin
            k <= k + 3'd1;
            r <= k + 3'd1;
          end
        end
        default: ;
      endcase
      // results change only as the run completes
      if (state_n == S_DONE && state != S_DONE) begin
        res      <= m;
        piv_q    <= piv;
        singular <= (state == S_SEARCH);
      end
    end
  end

  assign pivot1 = piv_q[0];
  assign pivot2 = piv_q[1];
  assign pivot3 = piv_q[2];
  assign pivot4 = piv_q[3];
  assign pivot5 = piv_q[4];

  assign i11 = res[0][0];
  assign i12 = res[0][1];
  assign i13 = res[0][2];
  assign i14 = res[0][3];
  assign i15 = res[0][4];
  assign i21 = res[1][0];
  assign i22 = res[1][1];
  assign i23 = res[1][2];
  assign i24 = res[1][3];
  assign i25 = res[1][4];
  assign i31 = res[2][0];
  assign i32 = res[2][1];
  assign i33 = res[2][2];
  assign i34 = res[2][3];
  assign i35 = res[2][4];
  assign i41 = res[3][0];
  assign i42 = res[3][1];
  assign i43 = res[3][2];
  assign i44 = res[3][3];
  assign i45 = res[3][4];
  assign i51 = res[4][0];
  assign i52 = res[4][1];
  assign i53 = res[4][2];
  assign i54 = res[4][3];
  assign i55 = res[4][4];

endmodule

// File: tb/tb_rref_2.sv
// tb_rref_2: directed vectors for the Bareiss reducer
// with hand-computed matrices and pivots.
module tb_rref_2;

  logic clk = 1'b0;
  logic rst, start;
  logic [31:0] am [5][5];
  logic [31:0] iq [5][5];
  logic [31:0] pv [5];
  logic busy, done, singular;

  int n_chk  = 0;
  int n_pass = 0;
  int n_done = 0;

  int em [5][5];
  int ep [5];
  bit es;

  int mx [5][5] = '{
    '{5, 3, 1, 7, 9},
    '{6, 4, 2, 8, -8},
    '{7, 5, 3, 10, 9},
    '{9, 6, 4, -9, -5},
    '{8, 5, 2, 11, 4}
  };

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) n_done++;

  rref_2 dut (
    .clk(clk), .rst(rst), .start(start),
    .a11(am[0][0]), .a12(am[0][1]), .a13(am[0][2]), .a14(am[0][3]), .a15(am[0][4]),
    .a21(am[1][0]), .a22(am[1][1]), .a23(am[1][2]), .a24(am[1][3]), .a25(am[1][4]),
    .a31(am[2][0]), .a32(am[2][1]), .a33(am[2][2]), .a34(am[2][3]), .a35(am[2][4]),
    .a41(am[3][0]), .a42(am[3][1]), .a43(am[3][2]), .a44(am[3][3]), .a45(am[3][4]),
    .a51(am[4][0]), .a52(am[4][1]), .a53(am[4][2]), .a54(am[4][3]), .a55(am[4][4]),
    .i11(iq[0][0]), .i12(iq[0][1]), .i13(iq[0][2]), .i14(iq[0][3]), .i15(iq[0][4]),
    .i21(iq[1][0]), .i22(iq[1][1]), .i23(iq[1][2]), .i24(iq[1][3]), .i25(iq[1][4]),
    .i31(iq[2][0]), .i32(iq[2][1]), .i33(iq[2][2]), .i34(iq[2][3]), .i35(iq[2][4]),
    .i41(iq[3][0]), .i42(iq[3][1]), .i43(iq[3][2]), .i44(iq[3][3]), .i45(iq[3][4]),
    .i51(iq[4][0]), .i52(iq[4][1]), .i53(iq[4][2]), .i54(iq[4][3]), .i55(iq[4][4]),
    .pivot1(pv[0]), .pivot2(pv[1]), .pivot3(pv[2]),
    .pivot4(pv[3]), .pivot5(pv[4]),
    .busy(busy), .done(done), .singular(singular)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d",
                  tag, $signed(got), $signed(exp));
  endtask

  task automatic fill(input int v);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) am[r][c] = v;
  endtask

  task automatic set_diag(input int d0, d1, d2, d3, d4);
    fill(0);
    am[0][0] = d0; am[1][1] = d1; am[2][2] = d2;
    am[3][3] = d3; am[4][4] = d4;
  endtask

  task automatic exp_diag(input int d, input bit s);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) em[r][c] = (r == c) ? d : 0;
    es = s;
  endtask

  task automatic exp_piv(input int p0, p1, p2, p3, p4);
    ep[0] = p0; ep[1] = p1; ep[2] = p2; ep[3] = p3; ep[4] = p4;
  endtask

  task automatic chk_res(input string name);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        chk($sformatf("%s i%0d%0d", name, r + 1, c + 1),
            iq[r][c], em[r][c]);
    for (int p = 0; p < 5; p++)
      chk($sformatf("%s pivot%0d", name, p + 1), pv[p], ep[p]);
    chk($sformatf("%s singular", name), {31'b0, singular}, {31'b0, es});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 4000; t++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run(input string name);
    bit ok;
    pulse_start();
    wait_done(ok);
    chk($sformatf("%s done", name), {31'b0, ok}, 32'd1);
    chk($sformatf("%s busy", name), {31'b0, busy}, 32'd0);
    chk_res(name);
    @(posedge clk); #1;
    chk($sformatf("%s pulse", name), {31'b0, done}, 32'd0);
  endtask

  initial begin
    bit ok;
    int nd;
    rst = 1'b1;
    start = 1'b0;
    fill(0);
    repeat (3) @(posedge clk);
    #1;
    exp_diag(0, 1'b0);
    exp_piv(0, 0, 0, 0, 0);
    chk_res("reset");
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset done", {31'b0, done}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    set_diag(1, 1, 1, 1, 1);
    exp_diag(1, 1'b0);
    exp_piv(1, 1, 1, 1, 1);
    run("ident");

    set_diag(2, 3, 4, 5, 6);
    exp_diag(720, 1'b0);
    exp_piv(2, 6, 24, 120, 720);
    run("diag");

    set_diag(0, 0, 1, 1, 1);
    am[0][1] = 1;
    am[1][0] = 1;
    exp_diag(1, 1'b0);
    exp_piv(1, 1, 1, 1, 1);
    run("swap");

    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) am[r][c] = mx[r][c];
    exp_diag(-2, 1'b0);
    exp_piv(5, 2, 2, 2, -2);
    run("mixed");

    fill(1);
    exp_diag(0, 1'b1);
    for (int c = 0; c < 5; c++) em[0][c] = 1;
    exp_piv(1, 0, 0, 0, 0);
    run("ones");

    set_diag(2, 3, 4, 5, 6);
    pulse_start();
    repeat (150) @(posedge clk);
    #1;
    chk("abort busy", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    start = 1'b0;
    exp_diag(0, 1'b0);
    exp_piv(0, 0, 0, 0, 0);
    chk_res("abort");
    chk("abort busy low", {31'b0, busy}, 32'd0);
    chk("abort done", {31'b0, done}, 32'd0);
    nd = n_done;
    repeat (100) @(posedge clk);
    #1;
    chk("abort no done", n_done - nd, 32'd0);

    set_diag(1, 1, 1, 1, 1);
    pulse_start();
    repeat (50) @(posedge clk);
    #1;
    fill(1);
    pulse_start();
    wait_done(ok);
    chk("restart done", {31'b0, ok}, 32'd1);
    exp_diag(1, 1'b0);
    exp_piv(1, 1, 1, 1, 1);
    chk_res("restart");
    repeat (200) @(posedge clk);
    #1;
    chk("restart one done", n_done - nd, 32'd1);
    chk("restart idle", {31'b0, busy}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
